bp_update_controller: RTL and testbench
=======================================

// Module: bp_update_controller
// PURPOSE
//  Sequences the correlating branch predictor between fetch and execute. Arbitrates the
//  predictor's single lookup/update port, keeps the speculative global history register (GHR),
//  and tracks in-flight predictions in an in-order queue. Trains the predictor on resolution,
//  flags mispredicts with GHR repair, and keeps accuracy statistics.
// PARAMETERS
//  M      2   global history bits (predictor m)
//  DEPTH  8   max outstanding predictions; power of 2, >=2
//  PC_W   32  PC width
//  CNT_W  32  statistics counter width
// PORTS
//  clk          in   1      rising-edge clock
//  rst_n        in   1      asynchronous active-low reset
//  lk_valid     in   1      fetch lookup request
//  lk_ready     out  1      lookup accepted when lk_valid&lk_ready
//  lk_pc        in   PC_W   lookup PC
//  rsp_valid    out  1      prediction response, 1 cycle after accept
//  rsp_taken    out  1      predicted direction
//  rs_valid     in   1      execute resolution (program order)
//  rs_ready     out  1      resolution accepted when rs_valid&rs_ready
//  rs_taken     in   1      actual outcome
//  bp_en        out  1      predictor port enable
//  bp_we        out  1      1=update, 0=lookup
//  bp_pc        out  PC_W   PC to predictor
//  bp_hist      out  M      history to predictor
//  bp_outcome   out  1      training outcome (valid when bp_we)
//  bp_pred      in   1      predictor direction, combinational from bp_pc/bp_hist
//  mispredict   out  1      1-cycle pulse: queue flushed, GHR repaired
//  cnt_total    out  CNT_W  resolved branches, saturating
//  cnt_correct  out  CNT_W  correctly predicted branches, saturating
// BEHAVIOUR
//  Reset (async, rst_n=0): queue empty, ptrs/count 0, GHR 0, rsp_valid/rsp_taken/mispredict 0,
//   counters 0. Outputs leave reset values on the first clk edge after rst_n rises.
//   Reset mid-operation discards all in-flight entries.
//  Queue entry = {pc, pred, ghr_snapshot}; circular, wrap-around ptrs, count 0..DEPTH.
//  rs_ready = (count!=0). lk_ready = (count!=DEPTH) & !(rs_valid&rs_ready).
//  Port arbitration, combinational per cycle; update has priority:
//   UPDATE if rs_valid&rs_ready: bp_en=1, bp_we=1, bp_pc=head.pc, bp_hist=head.snap,
//     bp_outcome=rs_taken.
//   else LOOKUP if lk_valid&lk_ready: bp_en=1, bp_we=0, bp_pc=lk_pc, bp_hist=GHR.
//   else IDLE: bp_en=0, bp_we=0, other bp_* 0.
//  Lookup accept at edge: enqueue {lk_pc, bp_pred, GHR}; GHR <= {GHR[M-2:0], bp_pred};
//   next cycle rsp_valid=1, rsp_taken=bp_pred. One lookup per cycle max.
//  Resolve accept at edge: dequeue head; cnt_total++; cnt_correct++ if head.pred==rs_taken.
//   Counters saturate at all-ones.
//   If head.pred!=rs_taken: queue cleared (count=0, rd_ptr=wr_ptr);
//   GHR <= {head.snap[M-2:0], rs_taken}; mispredict=1 next cycle.
//   Otherwise the GHR is unchanged (already shifted speculatively).
//  Lookup and resolve are never accepted in the same cycle (lk_ready forced 0), so the
//   full/empty and flush cases never race. A full queue with a resolve frees one slot, and the
//   stalled lookup can be accepted the following cycle.
//  rs_valid with an empty queue: rs_ready=0, no update, counters unchanged.
// TESTING
//  1 Reset: rst_n=0 mid-stream with 3 entries -> all outputs 0 immediately; count 0,
//    GHR 00 after release.
//  2 Lookup pc=0x100, bp_pred=1 -> bp_en=1, bp_we=0, bp_hist=00; next cycle rsp_valid=1,
//    rsp_taken=1, GHR=01. Resolve taken=1 -> bp_we=1, bp_pc=0x100, bp_hist=00,
//    bp_outcome=1; cnt_total=1, cnt_correct=1, no mispredict.
//  3 Eight lookups with no resolves -> count=8, lk_ready=0, 9th held. One resolve -> 9th
//    accepted next cycle, pointers wrap correctly.
//  4 lk_valid and rs_valid same cycle -> bp_we=1 (update), lk_ready=0; lookup accepted the
//    following cycle.
//  5 Three lookups pred=1 (GHR 00->01->11->11); resolve head taken=0 -> mispredict pulse
//    1 cycle, count=0, GHR=00, cnt_total=1, cnt_correct=0.
//  6 rs_valid=1 with empty queue -> rs_ready=0, bp_en=0, counters unchanged.
//    Saturation: preload counters near max -> they hold at all-ones.

Source files
------------

// File: rtl/bp_update_controller.sv
// rtl/bp_update_controller.sv - branch predictor port arbiter, speculative GHR and in-flight queue
//
// Sits between fetch and execute. It shares the predictor's single port between
// lookups and training updates, with updates taking priority. It also keeps the
// speculative global history register and tracks in-flight predictions in order.
// On a wrong prediction it repairs the history. It also counts resolved branches
// and correct predictions.
//
// Ports:
//   clk, rst_n                   clock, asynchronous active-low reset
//   lk_valid/lk_ready/lk_pc      fetch lookup request
//   rsp_valid/rsp_taken          prediction returned one cycle after accept
//   rs_valid/rs_ready/rs_taken   in-order resolution from execute
//   bp_en/bp_we/bp_pc/bp_hist/
//   bp_outcome/bp_pred           predictor port (bp_pred is combinational)
//   mispredict                   one-cycle pulse when the queue is flushed
//   cnt_total/cnt_correct        saturating accuracy statistics
//
// M must be >= 2 and DEPTH must be a power of two >= 2.

module bp_update_controller #(
    parameter int M     = 2,
    parameter int DEPTH = 8,
    parameter int PC_W  = 32,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             lk_valid,
    output logic             lk_ready,
    input  logic [PC_W-1:0]  lk_pc,
    output logic             rsp_valid,
    output logic             rsp_taken,
    input  logic             rs_valid,
    output logic             rs_ready,
    input  logic             rs_taken,
    output logic             bp_en,
    output logic             bp_we,
    output logic [PC_W-1:0]  bp_pc,
    output logic [M-1:0]     bp_hist,
    output logic             bp_outcome,
    input  logic             bp_pred,
    output logic             mispredict,
    output logic [CNT_W-1:0] cnt_total,
    output logic [CNT_W-1:0] cnt_correct
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    // Entry storage has no reset: an entry is only read while count covers it.
    logic [PC_W-1:0] q_pc   [DEPTH];
    logic [M-1:0]    q_snap [DEPTH];
    logic [DEPTH-1:0] q_pred;

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [M-1:0]  ghr;

    logic            rs_fire;
    logic            lk_fire;
    logic            mis;
    logic [PC_W-1:0] head_pc;
    logic [M-1:0]    head_snap;
    logic            head_pred;

    assign head_pc   = q_pc[rd_ptr];
    assign head_snap = q_snap[rd_ptr];
    assign head_pred = q_pred[rd_ptr];

    // A resolve blocks lookup in the same cycle. As a result, a flush and an
    // enqueue never race, and full/empty tracking needs no simultaneous case.
    assign rs_ready = (count != '0);
    assign rs_fire  = rs_valid & rs_ready;
    assign lk_ready = (count != FULL) & ~rs_fire;
    assign lk_fire  = lk_valid & lk_ready;
    assign mis      = rs_fire & (head_pred != rs_taken);

    always_comb begin
        bp_en      = 1'b0;
        bp_we      = 1'b0;
        bp_pc      = '0;
        bp_hist    = '0;
        bp_outcome = 1'b0;
        if (rs_fire) begin
            bp_en      = 1'b1;
            bp_we      = 1'b1;
            bp_pc      = head_pc;
            bp_hist    = head_snap;
            bp_outcome = rs_taken;
        end else if (lk_fire) begin
            bp_en   = 1'b1;
            bp_pc   = lk_pc;
            bp_hist = ghr;
        end
    end

    always_ff @(posedge clk) begin
        if (lk_fire) begin
            q_pc[wr_ptr]   <= lk_pc;
            q_snap[wr_ptr] <= ghr;
            q_pred[wr_ptr] <= bp_pred;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            ghr         <= '0;
            rsp_valid   <= 1'b0;
            rsp_taken   <= 1'b0;
            mispredict  <= 1'b0;
            cnt_total   <= '0;
            cnt_correct <= '0;
        end else begin
            rsp_valid  <= lk_fire;
            rsp_taken  <= lk_fire & bp_pred;
            mispredict <= mis;

            if (lk_fire) begin
                wr_ptr <= wr_ptr + AW'(1);
                count  <= count + (AW+1)'(1);
                ghr    <= {ghr[M-2:0], bp_pred};
            end

            if (rs_fire) begin
                if (cnt_total != '1) begin
                    cnt_total <= cnt_total + CNT_W'(1);
                end
                if (!mis && (cnt_correct != '1)) begin
                    cnt_correct <= cnt_correct + CNT_W'(1);
                end
                if (mis) begin
                    // Younger entries came from the wrong path. Drop them and
                    // rebuild history from the branch's snapshot and its real outcome.
                    count  <= '0;
                    rd_ptr <= wr_ptr;
                    ghr    <= {head_snap[M-2:0], rs_taken};
                end else begin
                    rd_ptr <= rd_ptr + AW'(1);
                    count  <= count - (AW+1)'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_bp_update_controller.sv
// tb/tb_bp_update_controller.sv - directed scoreboard bench for bp_update_controller

module tb_bp_update_controller;

    localparam int M     = 2;
    localparam int DEPTH = 8;
    localparam int PC_W  = 32;
    localparam int CNT_W = 4;
    localparam logic [31:0] CMAX = 32'd15;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             lk_valid;
    logic             lk_ready;
    logic [PC_W-1:0]  lk_pc;
    logic             rsp_valid;
    logic             rsp_taken;
    logic             rs_valid;
    logic             rs_ready;
    logic             rs_taken;
    logic             bp_en;
    logic             bp_we;
    logic [PC_W-1:0]  bp_pc;
    logic [M-1:0]     bp_hist;
    logic             bp_outcome;
    logic             bp_pred;
    logic             mispredict;
    logic [CNT_W-1:0] cnt_total;
    logic [CNT_W-1:0] cnt_correct;

    bp_update_controller #(.M(M), .DEPTH(DEPTH), .PC_W(PC_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .lk_valid(lk_valid), .lk_ready(lk_ready), .lk_pc(lk_pc),
        .rsp_valid(rsp_valid), .rsp_taken(rsp_taken),
        .rs_valid(rs_valid), .rs_ready(rs_ready), .rs_taken(rs_taken),
        .bp_en(bp_en), .bp_we(bp_we), .bp_pc(bp_pc), .bp_hist(bp_hist),
        .bp_outcome(bp_outcome), .bp_pred(bp_pred),
        .mispredict(mispredict), .cnt_total(cnt_total), .cnt_correct(cnt_correct)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic        pred;
        logic [1:0]  snap;
    } entry_t;

    entry_t      sb[$];
    logic        rsp_q[$];
    logic [1:0]  m_ghr;
    logic [31:0] m_total;
    logic [31:0] m_correct;
    int          n_assert;
    int          n_fail;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_model();
        sb.delete();
        rsp_q.delete();
        m_ghr     = 2'b00;
        m_total   = 0;
        m_correct = 0;
    endtask

    // Called at posedge+1; returns at the next posedge+1 with lk_valid dropped.
    task automatic lookup(input logic [31:0] pc, input logic pred);
        entry_t e;
        lk_valid = 1'b1;
        lk_pc    = pc;
        bp_pred  = pred;
        #1;
        chk("lk_ready", 32'(lk_ready), 1);
        chk("lk_bp_en", 32'(bp_en), 1);
        chk("lk_bp_we", 32'(bp_we), 0);
        chk("lk_bp_pc", bp_pc, pc);
        chk("lk_bp_hist", 32'(bp_hist), 32'(m_ghr));
        e.pc = pc; e.pred = pred; e.snap = m_ghr;
        sb.push_back(e);
        rsp_q.push_back(pred);
        m_ghr = {m_ghr[0], pred};
        @(posedge clk); #1;
        lk_valid = 1'b0;
        bp_pred  = 1'b0;
        chk("rsp_valid", 32'(rsp_valid), 1);
        if (rsp_q.size() != 0) chk("rsp_taken", 32'(rsp_taken), 32'(rsp_q.pop_front()));
        else chk("rsp_queue_empty", 32'(rsp_valid), 0);
    endtask

    task automatic resolve(input logic taken);
        entry_t e;
        logic   mis;
        if (sb.size() == 0) begin
            chk("resolve_model_empty", 32'(rs_ready), 1);
            return;
        end
        e = sb.pop_front();
        rs_valid = 1'b1;
        rs_taken = taken;
        #1;
        chk("rs_ready", 32'(rs_ready), 1);
        chk("rs_lk_ready", 32'(lk_ready), 0);
        chk("rs_bp_en", 32'(bp_en), 1);
        chk("rs_bp_we", 32'(bp_we), 1);
        chk("rs_bp_pc", bp_pc, e.pc);
        chk("rs_bp_hist", 32'(bp_hist), 32'(e.snap));
        chk("rs_bp_outcome", 32'(bp_outcome), 32'(taken));
        mis = (e.pred != taken);
        if (m_total != CMAX) m_total++;
        if (!mis && m_correct != CMAX) m_correct++;
        if (mis) begin
            sb.delete();
            m_ghr = {e.snap[0], taken};
        end
        @(posedge clk); #1;
        rs_valid = 1'b0;
        rs_taken = 1'b0;
        chk("mispredict", 32'(mispredict), 32'(mis));
        chk("cnt_total", 32'(cnt_total), m_total);
        chk("cnt_correct", 32'(cnt_correct), m_correct);
    endtask

    task automatic resolve_ok();
        if (sb.size() != 0) resolve(sb[0].pred);
        else chk("resolve_ok_model_empty", 32'(rs_ready), 1);
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        clear_model();
        rst_n    = 1'b0;
        lk_valid = 1'b0;
        lk_pc    = '0;
        rs_valid = 1'b0;
        rs_taken = 1'b0;
        bp_pred  = 1'b0;
        #1;
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_mispredict", 32'(mispredict), 0);
        chk("rst_cnt_total", 32'(cnt_total), 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        chk("idle_rs_ready", 32'(rs_ready), 0);
        chk("idle_lk_ready", 32'(lk_ready), 1);
        chk("idle_bp_en", 32'(bp_en), 0);

        // Basic lookup then correct resolve
        lookup(32'h100, 1'b1);
        resolve(1'b1);
        chk("no_mis_followup", 32'(mispredict), 0);

        // Resolve with an empty queue
        rs_valid = 1'b1;
        rs_taken = 1'b1;
        #1;
        chk("empty_rs_ready", 32'(rs_ready), 0);
        chk("empty_bp_en", 32'(bp_en), 0);
        @(posedge clk); #1;
        rs_valid = 1'b0;
        chk("empty_cnt_total", 32'(cnt_total), m_total);
        chk("empty_cnt_correct", 32'(cnt_correct), m_correct);
        chk("empty_mispredict", 32'(mispredict), 0);

        // Fill the queue, hold the ninth lookup, free one slot, then drain
        for (int i = 0; i < DEPTH; i++) lookup(32'h200 + 32'(i * 4), i[0]);
        lk_valid = 1'b1;
        lk_pc    = 32'h300;
        bp_pred  = 1'b1;
        #1;
        chk("full_lk_ready", 32'(lk_ready), 0);
        chk("full_bp_en", 32'(bp_en), 0);
        @(posedge clk); #1;
        chk("full_rsp_valid", 32'(rsp_valid), 0);
        resolve_ok();
        lookup(32'h300, 1'b1);
        for (int i = 0; i < DEPTH; i++) resolve_ok();
        chk("drained_rs_ready", 32'(rs_ready), 0);

        // Lookup and resolve presented together: update wins
        lookup(32'h400, 1'b0);
        lk_valid = 1'b1;
        lk_pc    = 32'h404;
        bp_pred  = 1'b1;
        resolve_ok();
        lookup(32'h404, 1'b1);
        resolve_ok();

        // Asynchronous reset with three entries in flight
        lookup(32'h500, 1'b1);
        lookup(32'h504, 1'b0);
        lookup(32'h508, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("midrst_rsp_valid", 32'(rsp_valid), 0);
        chk("midrst_rsp_taken", 32'(rsp_taken), 0);
        chk("midrst_cnt_total", 32'(cnt_total), 0);
        chk("midrst_cnt_correct", 32'(cnt_correct), 0);
        chk("midrst_mispredict", 32'(mispredict), 0);
        clear_model();
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        chk("postrst_rs_ready", 32'(rs_ready), 0);
        @(posedge clk); #1;

        // Mispredict: GHR 00->01->11->11, head resolves not-taken
        lookup(32'h600, 1'b1);
        lookup(32'h604, 1'b1);
        lookup(32'h608, 1'b1);
        resolve(1'b0);
        chk("mis_rs_ready", 32'(rs_ready), 0);
        @(posedge clk); #1;
        chk("mis_pulse_end", 32'(mispredict), 0);
        lookup(32'h700, 1'b0);
        resolve_ok();

        // Saturation of both counters
        for (int i = 0; i < 18; i++) begin
            lookup(32'h800 + 32'(i * 4), i[1]);
            resolve_ok();
        end
        chk("sat_total", 32'(cnt_total), CMAX);
        chk("sat_correct", 32'(cnt_correct), CMAX);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
